dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Data-memory load/store unit sitting between the core's memory stage and the four byte-wide `ram0`..`ram3` data banks. It drives port 1 of each bank. It splits each byte, half or word access into per-lane bank addresses and write strobes, supporting misaligned accesses in a single cycle via per-lane row addresses. It then realigns and sign- or zero-extends the bank read bytes into a registered 32-bit response two cycles after acceptance.

## Interface
- `ROWS`, default 32768: number of valid rows per bank; a bank row index must be `< ROWS`.
- `ALLOW_MISALIGNED`, default 1: if 0, half accesses with `addr[0]!=0` and word accesses with `addr[1:0]!=0` are errors.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a cycle with `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned` in 1: load zero-extends if 1, sign-extends if 0.
- `req_wdata` in 32: store data, LSB-aligned.
- `bank_we` out 4: per-lane write enable; bit l drives `we1` of bank l.
- `bank_rw_num0..3` out 32 each: row index to bank l `rw_num1`.
- `bank_w_data0..3` out 8 each: write byte to bank l.
- `bank_r_data0..3` in 8 each: bank l `r_data1`, valid one cycle after the row is presented.
- `resp_valid` out 1: one-cycle pulse per accepted request, loads and stores.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: request was illegal or out of range.

## Operation
- `req_ready = !rst`. The unit is fully pipelined, with no backpressure, and accepts every cycle.
- Lane row computation: `base = req_addr[31:2]` and `off = req_addr[1:0]`. Lane l row is `base + (l < off ? 1 : 0)`, computed in 33-bit arithmetic; the carry is kept for the range check.
- Byte mapping: access byte i, for i < n with n = 1/2/4, maps to lane `(off+i) mod 4`.
- Touched lanes: the n lanes so mapped. A lane is touched only if it is one of these.
- Error conditions:
  - `req_size==3`.
  - Misalignment with `ALLOW_MISALIGNED==0`.
  - Any touched lane's row `>= ROWS`, including 33-bit overflow at address wrap past 0xFFFFFFFF.
- Store:
  - `bank_we[l]=1` only for touched lanes when there is no error.
  - `bank_w_data` of lane `(off+i) mod 4` = `req_wdata[8i+7:8i]`.
  - Untouched lanes: `we=0`, `w_data=0`.
- Load: all `bank_we=0`.
- Stage S1 register, captured on accept: `v1`, `we1`, `off1`, `size1`, `uns1`, `err1`.
- Stage S2: assembles byte i from lane `(off1+i) mod 4` and extends from bit `8n-1` unless `uns1`, then registers `resp_*`.
- The bank outputs `bank_*` are combinational from the request. They are gated by `req_valid && !rst`; while idle, `bank_we=0` and the row outputs follow `req_addr`.

## Timing
- Cycle 0: request accepted; bank write commits at the cycle-0 edge.
- Cycle 1: bank read bytes are valid.
- Cycle 2: `resp_valid`, `resp_rdata` and `resp_err` are valid for one cycle. Latency is exactly 2 for every request.
- Back-to-back requests produce back-to-back responses in order.
- Store then load to the same byte in the next cycle: the load returns the stored value, because the bank write precedes the read.
- Store and load in the same cycle is not possible, since there is one request per cycle.
- Reset values, cleared at the next edge:
  - `resp_valid=0`, `resp_rdata=0`, `resp_err=0`.
  - `v1=0`.
  - `bank_we=0` while `rst` is high.
- Reset mid-operation: in-flight responses are dropped with no `resp_valid`. Writes already committed remain in the banks.

## Structure
- Package `lsu_pkg`:
  - `SIZE_B/SIZE_H/SIZE_W` encodings.
  - `LANES=4`.
  - A function returning the byte count n for a size.
- Sub-module `lsu_load_align`: combinational rotate plus sign/zero extension (inputs: four lane bytes, `off`, `size`, `unsigned`; output: 32-bit data).
- The top level holds the lane/row computation, the error check, the S1 and S2 registers, and the bank fan-out.

## Test plan
- Aligned word store of 0xDEADBEEF to addr 0x100, then word load from 0x100 → `bank_we=4'b1111`, all rows 0x40; the load gives `resp_rdata=0xDEADBEEF` at cycle +2 with `resp_err=0`.
- Byte load from 0x103, signed and unsigned, with the byte = 0x80 → signed returns 0xFFFFFF80; unsigned returns 0x00000080.
- Misaligned word store of 0x11223344 to 0x102 → lanes 2,3 at row 0x40 and lanes 0,1 at row 0x41. Reading back from 0x102 gives 0x11223344. With `ALLOW_MISALIGNED=0`, the store sets `resp_err=1` and `bank_we=0`.
- Word load at `(ROWS*4)-2` → touched row == `ROWS`: `resp_err=1` and `resp_rdata=0`. Also `req_size=3` → `resp_err=1`.
- Four back-to-back loads from 0x0/0x1/0x2/0x3 with size=byte → four consecutive `resp_valid` pulses in order with the correct bytes.
- Assert `rst` one cycle after accepting a load → no `resp_valid`, all outputs 0; a store accepted before `rst` is visible on a subsequent load.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the data-memory load/store unit.
package lsu_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } size_e;

  // Number of bytes moved by an access of the given size; 0 for the illegal code.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_B:  n = 3'd1;
      SIZE_H:  n = 3'd2;
      SIZE_W:  n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bus between the memory stage and the load/store unit.
interface dmem_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_load_align.sv
// Rotates the four bank bytes into access order and sign/zero-extends the result.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [LANES-1:0][7:0] lanes,
  input  logic [1:0]            off,
  input  logic [1:0]            size,
  input  logic                  uns,
  output logic [31:0]           data
);

  logic [31:0] word_s;
  logic        ext_s;

  // Byte i of the access lives in lane (off+i) mod 4; the 2-bit sum wraps for free.
  always_comb begin
    word_s = 32'd0;
    for (int i = 0; i < LANES; i++) begin
      word_s[8*i +: 8] = lanes[2'(off + 2'(i))];
    end
  end

  // Extend from the top bit of the accessed width unless a zero-extend load.
  always_comb begin
    ext_s = 1'b0;
    data  = 32'd0;
    case (size)
      SIZE_B: begin
        ext_s = uns ? 1'b0 : word_s[7];
        data  = {{24{ext_s}}, word_s[7:0]};
      end
      SIZE_H: begin
        ext_s = uns ? 1'b0 : word_s[15];
        data  = {{16{ext_s}}, word_s[15:0]};
      end
      SIZE_W: begin
        data = word_s;
      end
      default: begin
        data = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: per-lane row/strobe fan-out to four byte banks and a
// two-stage registered load response with realignment and extension.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ROWS             = 32768,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_lsu_if.slave   bus,
  output logic [3:0]  bank_we,
  output logic [31:0] bank_rw_num0,
  output logic [31:0] bank_rw_num1,
  output logic [31:0] bank_rw_num2,
  output logic [31:0] bank_rw_num3,
  output logic [7:0]  bank_w_data0,
  output logic [7:0]  bank_w_data1,
  output logic [7:0]  bank_w_data2,
  output logic [7:0]  bank_w_data3,
  input  logic [7:0]  bank_r_data0,
  input  logic [7:0]  bank_r_data1,
  input  logic [7:0]  bank_r_data2,
  input  logic [7:0]  bank_r_data3
);

  localparam logic [32:0] ROWS_W = 33'(ROWS);

  logic [29:0]      base_s;
  logic [1:0]       off_s;
  logic [2:0]       nbytes_s;
  logic [1:0]       lane_idx_s [LANES];
  logic [32:0]      row_s      [LANES];
  logic [7:0]       wbyte_s    [LANES];
  logic [LANES-1:0] touched_s;
  logic [LANES-1:0] oor_s;
  logic             mis_s;
  logic             err_s;
  logic             acc_s;
  logic             store_s;
  logic [31:0]      load_data_s;

  logic             v1_r;
  logic             we1_r;
  logic [1:0]       off1_r;
  logic [1:0]       size1_r;
  logic             uns1_r;
  logic             err1_r;

  logic             resp_valid_r;
  logic [31:0]      resp_rdata_r;
  logic             resp_err_r;

  // Per-lane row (33-bit so a wrap past the top of memory still trips the range check),
  // access byte index, touched flag and candidate write byte.
  always_comb begin
    base_s   = bus.req_addr[31:2];
    off_s    = bus.req_addr[1:0];
    nbytes_s = size_bytes(bus.req_size);
    for (int l = 0; l < LANES; l++) begin
      lane_idx_s[l] = 2'(l) - off_s;
      row_s[l]      = {3'b000, base_s} + ((2'(l) < off_s) ? 33'd1 : 33'd0);
      touched_s[l]  = ({1'b0, lane_idx_s[l]} < nbytes_s);
      oor_s[l]      = (row_s[l] >= ROWS_W);
      wbyte_s[l]    = touched_s[l] ? bus.req_wdata[{lane_idx_s[l], 3'b000} +: 8] : 8'd0;
    end
  end

  // Misalignment only counts as an error when the build forbids it.
  always_comb begin
    mis_s = 1'b0;
    if (ALLOW_MISALIGNED) begin
      mis_s = 1'b0;
    end else begin
      case (bus.req_size)
        SIZE_H:  mis_s = bus.req_addr[0];
        SIZE_W:  mis_s = |bus.req_addr[1:0];
        default: mis_s = 1'b0;
      endcase
    end
  end

  // Error summary and bank fan-out; strobes only for touched lanes of a clean store.
  always_comb begin
    err_s   = (bus.req_size == SIZE_X) | mis_s | (|(touched_s & oor_s));
    acc_s   = bus.req_valid & ~rst;
    store_s = acc_s & bus.req_we;
    if (store_s && !err_s) begin
      bank_we = touched_s;
    end else begin
      bank_we = 4'b0000;
    end
    if (store_s) begin
      bank_w_data0 = wbyte_s[0];
      bank_w_data1 = wbyte_s[1];
      bank_w_data2 = wbyte_s[2];
      bank_w_data3 = wbyte_s[3];
    end else begin
      bank_w_data0 = 8'd0;
      bank_w_data1 = 8'd0;
      bank_w_data2 = 8'd0;
      bank_w_data3 = 8'd0;
    end
    bank_rw_num0 = row_s[0][31:0];
    bank_rw_num1 = row_s[1][31:0];
    bank_rw_num2 = row_s[2][31:0];
    bank_rw_num3 = row_s[3][31:0];
  end

  assign bus.req_ready = ~rst;

  // S1: remember what was accepted while the banks fetch the read bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r    <= 1'b0;
      we1_r   <= 1'b0;
      off1_r  <= 2'd0;
      size1_r <= 2'd0;
      uns1_r  <= 1'b0;
      err1_r  <= 1'b0;
    end else begin
      v1_r    <= bus.req_valid;
      we1_r   <= bus.req_we;
      off1_r  <= off_s;
      size1_r <= bus.req_size;
      uns1_r  <= bus.req_unsigned;
      err1_r  <= err_s;
    end
  end

  lsu_load_align u_align (
    .lanes ({bank_r_data3, bank_r_data2, bank_r_data1, bank_r_data0}),
    .off   (off1_r),
    .size  (size1_r),
    .uns   (uns1_r),
    .data  (load_data_s)
  );

  // S2: registered response; data is zero for stores and errored requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      resp_valid_r <= v1_r;
      resp_err_r   <= v1_r & err1_r;
      resp_rdata_r <= (v1_r && !we1_r && !err1_r) ? load_data_s : 32'd0;
    end
  end

  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: byte-bank model, fixed-latency response scoreboard,
// plus a second instance built with misaligned accesses disallowed.
module tb_dmem_lsu;
  import lsu_pkg::*;

  localparam int unsigned ROWS = 32768;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_lsu_if bus0();
  dmem_lsu_if bus1();

  logic [3:0]  we0;
  logic [31:0] rw0 [4];
  logic [7:0]  wd0 [4];
  logic [7:0]  rd0 [4];
  logic [3:0]  we1;
  logic [31:0] rw1 [4];
  logic [7:0]  wd1 [4];
  logic [7:0]  mem [4][ROWS];

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  exp_t q[$];

  dmem_lsu #(.ROWS(ROWS), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0), .bank_we(we0),
    .bank_rw_num0(rw0[0]), .bank_rw_num1(rw0[1]), .bank_rw_num2(rw0[2]), .bank_rw_num3(rw0[3]),
    .bank_w_data0(wd0[0]), .bank_w_data1(wd0[1]), .bank_w_data2(wd0[2]), .bank_w_data3(wd0[3]),
    .bank_r_data0(rd0[0]), .bank_r_data1(rd0[1]), .bank_r_data2(rd0[2]), .bank_r_data3(rd0[3])
  );

  dmem_lsu #(.ROWS(ROWS), .ALLOW_MISALIGNED(1'b0)) u_dut_al (
    .clk(clk), .rst(rst), .bus(bus1), .bank_we(we1),
    .bank_rw_num0(rw1[0]), .bank_rw_num1(rw1[1]), .bank_rw_num2(rw1[2]), .bank_rw_num3(rw1[3]),
    .bank_w_data0(wd1[0]), .bank_w_data1(wd1[1]), .bank_w_data2(wd1[2]), .bank_w_data3(wd1[3]),
    .bank_r_data0(8'h00), .bank_r_data1(8'h00), .bank_r_data2(8'h00), .bank_r_data3(8'h00)
  );

  // Four byte-wide banks: write on the edge, registered read of the presented row.
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we0[l] && rw0[l] < ROWS) mem[l][rw0[l][14:0]] <= wd0[l];
      rd0[l] <= (rw0[l] < ROWS) ? mem[l][rw0[l][14:0]] : 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: every cycle either the due response or an idle bus.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        check("resp_valid", {31'd0, bus0.resp_valid}, 32'd1);
        check("resp_rdata", bus0.resp_rdata, q[0].data);
        check("resp_err",   {31'd0, bus0.resp_err}, {31'd0, q[0].err});
        void'(q.pop_front());
      end else begin
        check("resp_idle", {31'd0, bus0.resp_valid}, 32'd0);
      end
    end
  end

  task automatic req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wd,
                     input logic [31:0] ed, input logic ee);
    @(negedge clk);
    bus0.req_valid    = 1'b1;
    bus0.req_we       = we;
    bus0.req_addr     = addr;
    bus0.req_size     = size;
    bus0.req_unsigned = uns;
    bus0.req_wdata    = wd;
    q.push_back('{cyc + 2, ed, ee});
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus0.req_valid = 1'b0;
      bus0.req_we    = 1'b0;
    end
  endtask

  task automatic chk_rows(input string tag, input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] r3);
    check({tag, "_row0"}, rw0[0], r0);
    check({tag, "_row1"}, rw0[1], r1);
    check({tag, "_row2"}, rw0[2], r2);
    check({tag, "_row3"}, rw0[3], r3);
  endtask

  // Misaligned-disallowed instance: one request, strobe check, response two edges later.
  task automatic req_al(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic [3:0] exp_we, input logic exp_err);
    @(negedge clk);
    bus1.req_valid    = 1'b1;
    bus1.req_we       = 1'b1;
    bus1.req_addr     = addr;
    bus1.req_size     = size;
    bus1.req_unsigned = 1'b0;
    bus1.req_wdata    = 32'h11223344;
    #1;
    check({tag, "_we"}, {28'd0, we1}, {28'd0, exp_we});
    @(negedge clk);
    bus1.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {31'd0, bus1.resp_valid}, 32'd1);
    check({tag, "_err"},   {31'd0, bus1.resp_err}, {31'd0, exp_err});
  endtask

  initial begin
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'd0;
    bus0.req_size = 2'd0; bus0.req_unsigned = 1'b0; bus0.req_wdata = 32'd0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = 32'd0;
    bus1.req_size = 2'd0; bus1.req_unsigned = 1'b0; bus1.req_wdata = 32'd0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus0.req_ready}, 32'd0);
    check("rst_rdata", bus0.resp_rdata, 32'd0);
    check("rst_err",   {31'd0, bus0.resp_err}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready", {31'd0, bus0.req_ready}, 32'd1);

    // aligned word store then load
    req(1'b1, 32'h100, SIZE_W, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0);
    check("sw_we", {28'd0, we0}, 32'h0000000F);
    chk_rows("sw", 32'h40, 32'h40, 32'h40, 32'h40);
    check("sw_wd0", {24'd0, wd0[0]}, 32'hEF);
    check("sw_wd3", {24'd0, wd0[3]}, 32'hDE);
    req(1'b0, 32'h100, SIZE_W, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0);
    check("lw_we", {28'd0, we0}, 32'd0);

    // byte 0x80 at 0x103, signed and unsigned loads
    req(1'b1, 32'h103, SIZE_B, 1'b0, 32'h00000080, 32'd0, 1'b0);
    check("sb_we", {28'd0, we0}, 32'h00000008);
    check("sb_wd3", {24'd0, wd0[3]}, 32'h80);
    check("sb_wd0", {24'd0, wd0[0]}, 32'h00);
    req(1'b0, 32'h103, SIZE_B, 1'b0, 32'd0, 32'hFFFFFF80, 1'b0);
    req(1'b0, 32'h103, SIZE_B, 1'b1, 32'd0, 32'h00000080, 1'b0);

    // misaligned word store crossing a row, read back, half loads
    req(1'b1, 32'h102, SIZE_W, 1'b0, 32'h11223344, 32'd0, 1'b0);
    check("msw_we", {28'd0, we0}, 32'h0000000F);
    chk_rows("msw", 32'h41, 32'h41, 32'h40, 32'h40);
    check("msw_wd0", {24'd0, wd0[0]}, 32'h22);
    check("msw_wd2", {24'd0, wd0[2]}, 32'h44);
    req(1'b0, 32'h102, SIZE_W, 1'b0, 32'd0, 32'h11223344, 1'b0);
    req(1'b0, 32'h101, SIZE_H, 1'b0, 32'd0, 32'h000044BE, 1'b0);
    req(1'b0, 32'h100, SIZE_H, 1'b0, 32'd0, 32'hFFFFBEEF, 1'b0);
    req(1'b0, 32'h100, SIZE_H, 1'b1, 32'd0, 32'h0000BEEF, 1'b0);

    // range boundary, illegal size, address wrap
    req(1'b0, ROWS * 4 - 2, SIZE_W, 1'b0, 32'd0, 32'd0, 1'b1);
    req(1'b1, ROWS * 4 - 2, SIZE_W, 1'b0, 32'h12345678, 32'd0, 1'b1);
    check("oor_we", {28'd0, we0}, 32'd0);
    req(1'b1, ROWS * 4 - 1, SIZE_B, 1'b0, 32'h0000005A, 32'd0, 1'b0);
    check("edge_we", {28'd0, we0}, 32'h00000008);
    chk_rows("edge", 32'h8000, 32'h8000, 32'h8000, 32'h7FFF);
    req(1'b0, ROWS * 4 - 1, SIZE_B, 1'b1, 32'd0, 32'h0000005A, 1'b0);
    req(1'b1, 32'h0, SIZE_X, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b1);
    check("x_we", {28'd0, we0}, 32'd0);
    req(1'b0, 32'hFFFFFFFE, SIZE_W, 1'b0, 32'd0, 32'd0, 1'b1);
    check("wrap_row0", rw0[0], 32'h40000000);

    // back-to-back byte loads, then store followed directly by load
    req(1'b1, 32'h0, SIZE_W, 1'b0, 32'h807F0102, 32'd0, 1'b0);
    req(1'b0, 32'h0, SIZE_B, 1'b0, 32'd0, 32'h00000002, 1'b0);
    req(1'b0, 32'h1, SIZE_B, 1'b0, 32'd0, 32'h00000001, 1'b0);
    req(1'b0, 32'h2, SIZE_B, 1'b0, 32'd0, 32'h0000007F, 1'b0);
    req(1'b0, 32'h3, SIZE_B, 1'b0, 32'd0, 32'hFFFFFF80, 1'b0);
    req(1'b1, 32'h200, SIZE_B, 1'b0, 32'h000000A5, 32'd0, 1'b0);
    req(1'b0, 32'h200, SIZE_B, 1'b1, 32'd0, 32'h000000A5, 1'b0);
    idle(4);

    // misaligned accesses rejected by the strict instance
    req_al("al_w102", 32'h102, SIZE_W, 4'b0000, 1'b1);
    req_al("al_w100", 32'h100, SIZE_W, 4'b1111, 1'b0);
    req_al("al_h101", 32'h101, SIZE_H, 4'b0000, 1'b1);
    req_al("al_h102", 32'h102, SIZE_H, 4'b1100, 1'b0);
    req_al("al_b103", 32'h103, SIZE_B, 4'b1000, 1'b0);

    // reset one cycle after a load is accepted drops its response
    req(1'b1, 32'h300, SIZE_W, 1'b0, 32'hCAFEF00D, 32'd0, 1'b0);
    req(1'b0, 32'h300, SIZE_W, 1'b0, 32'd0, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus0.req_valid = 1'b1;
    bus0.req_we    = 1'b1;
    bus0.req_wdata = 32'h0;
    q.delete();
    #1;
    check("rst_bank_we", {28'd0, we0}, 32'd0);
    check("rst_ready2", {31'd0, bus0.req_ready}, 32'd0);
    @(negedge clk);
    check("rst_rdata2", bus0.resp_rdata, 32'd0);
    check("rst_err2",   {31'd0, bus0.resp_err}, 32'd0);
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    rst = 1'b0;
    req(1'b0, 32'h300, SIZE_W, 1'b0, 32'd0, 32'hCAFEF00D, 1'b0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
